// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit basic processor: word width and the
// fetch FSM state encoding.
package proc_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Encoding 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        FETCH_IDLE = ST_IDLE,
        FETCH_REQ  = ST_REQ,
        FETCH_HOLD = ST_HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its neighbours: branch unit, instruction
// memory and decode. The master side is the fetch unit.
interface fetch_unit_if;
    import proc_pkg::*;

    // Handshakes: imem_req stays high with imem_addr stable until a cycle with
    // imem_ack=1, which completes that transfer (ack may come in the first req
    // cycle). Decode takes inst in any cycle where inst_valid=1 and stall=0.
    logic              bj;
    logic [WORD_W-1:0] br_target;
    logic              stall;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] inst_pc;
    logic              inst_valid;
    logic [1:0]        dbg_state;

    modport master (
        input  bj, br_target, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, inst, inst_pc, inst_valid, dbg_state
    );

    modport slave (
        output bj, br_target, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst, inst_pc, inst_valid, dbg_state
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one req/ack memory transfer at a
// time and holds the fetched word for decode; taken branches squash fetches.
module fetch_unit
    import proc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [WORD_W-1:0] PC_INC   = 16'h0001
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master io_bus
);

    fetch_state_e      r_state, w_state_nxt;
    logic [WORD_W-1:0] r_pc, w_pc_nxt;
    logic [WORD_W-1:0] r_addr, w_addr_nxt;
    logic [WORD_W-1:0] r_inst, w_inst_nxt;
    logic [WORD_W-1:0] r_inst_pc, w_inst_pc_nxt;
    logic              r_squash, w_squash_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;
    logic [WORD_W-1:0] w_seq_pc;

    assign w_seq_pc = r_addr + PC_INC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_squash     <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_addr       <= w_addr_nxt;
            r_squash     <= w_squash_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_addr_nxt       = r_addr;
        w_squash_nxt     = r_squash;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        case (r_state)
            FETCH_IDLE: begin
                w_state_nxt = FETCH_REQ;
                if (io_bus.bj) begin
                    w_pc_nxt   = io_bus.br_target;
                    w_addr_nxt = io_bus.br_target;
                end else begin
                    w_addr_nxt = r_pc;
                end
            end
            FETCH_REQ: begin
                // The address on the bus must not move mid-transfer, so a branch
                // during a pending request only marks it for discard.
                if (io_bus.imem_ack) begin
                    if (io_bus.bj) begin
                        w_squash_nxt = 1'b0;
                        w_pc_nxt     = io_bus.br_target;
                        w_addr_nxt   = io_bus.br_target;
                    end else if (r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_addr_nxt   = r_pc;
                    end else begin
                        w_inst_nxt       = io_bus.imem_rdata;
                        w_inst_pc_nxt    = r_addr;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = w_seq_pc;
                        w_state_nxt      = FETCH_HOLD;
                    end
                end else if (io_bus.bj) begin
                    w_pc_nxt     = io_bus.br_target;
                    w_squash_nxt = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (io_bus.bj) begin
                    w_inst_valid_nxt = 1'b0;
                    w_pc_nxt         = io_bus.br_target;
                    w_addr_nxt       = io_bus.br_target;
                    w_state_nxt      = FETCH_REQ;
                end else if (!io_bus.stall) begin
                    w_inst_valid_nxt = 1'b0;
                    w_addr_nxt       = r_pc;
                    w_state_nxt      = FETCH_REQ;
                end
            end
            default: begin
                w_state_nxt      = FETCH_IDLE;
                w_squash_nxt     = 1'b0;
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    assign io_bus.imem_req   = (r_state == FETCH_REQ);
    assign io_bus.imem_addr  = r_addr;
    assign io_bus.inst       = r_inst;
    assign io_bus.inst_pc    = r_inst_pc;
    assign io_bus.inst_valid = r_inst_valid;
    assign io_bus.dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized branch/stall/latency
// traffic, checked by a program-order fetch model and a delivery scoreboard.
module tb_fetch_unit;
    import proc_pkg::*;

    localparam logic [15:0] MAIN_RST_PC = 16'h0000;
    localparam logic [15:0] WRAP_RST_PC = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    fetch_unit #(.RESET_PC(MAIN_RST_PC), .PC_INC(16'h0001)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    fetch_unit #(.RESET_PC(WRAP_RST_PC), .PC_INC(16'h0001)) u_dut_w (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_w)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_deliv  = 0;
    logic [31:0] exp_q[$];

    int          lat_cfg       = 0;
    bit          lat_rand      = 1'b0;
    bit          mem_force_ack = 1'b0;
    bit          in_req        = 1'b0;
    int          wait_cnt      = 0;

    logic [15:0] m_exp_pc     = MAIN_RST_PC;
    bit          m_req_active = 1'b0;
    logic [15:0] m_req_addr   = '0;
    bit          m_tainted    = 1'b0;

    bit          mon_prev_valid = 1'b0;
    bit          mon_prev_drop  = 1'b0;
    logic [31:0] mon_held       = '0;
    logic [31:0] mon_got;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, {16'b0, act}, {16'b0, exp});
    endtask

    task automatic wait_req_addr(input string name, input logic [15:0] a, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == a) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    task automatic wait_valid_pc(input string name, input logic [15:0] a, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.inst_valid && bus.inst_pc == a) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    // Memory: word at address a is a^A5A5; ack after a configurable wait.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.imem_req) begin
                in_req         = 1'b0;
                bus.imem_ack   = mem_force_ack;
                bus.imem_rdata = mem_force_ack ? 16'hDEAD : 16'h0000;
            end else begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    wait_cnt = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
                end
                if (wait_cnt == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    in_req         = 1'b0;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = 16'($urandom);
                    wait_cnt--;
                end
            end
        end
    end

    // Zero-wait memory for the wrap-around instance.
    initial begin
        bus_w.imem_ack   = 1'b0;
        bus_w.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_w.imem_ack   = bus_w.imem_req;
            bus_w.imem_rdata = mem_word(bus_w.imem_addr);
        end
    end

    // Program-order model: the next delivered PC follows the last delivery by one,
    // unless a taken branch came since, in which case it is the latest target.
    // A memory response is delivered only if no branch hit its request or its ack.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_exp_pc     = MAIN_RST_PC;
                m_req_active = 1'b0;
                m_tainted    = 1'b0;
                exp_q.delete();
            end else begin
                if (bus.imem_req) begin
                    if (!m_req_active) begin
                        m_req_active = 1'b1;
                        m_req_addr   = bus.imem_addr;
                        m_tainted    = 1'b0;
                        chk16("req_addr", bus.imem_addr, m_exp_pc);
                    end else begin
                        chk16("addr_stable", bus.imem_addr, m_req_addr);
                    end
                    if (bus.imem_ack) begin
                        if (!bus.bj && !m_tainted) begin
                            exp_q.push_back({m_req_addr, mem_word(m_req_addr)});
                            m_exp_pc = m_req_addr + 16'h0001;
                        end
                        m_req_active = 1'b0;
                    end else if (bus.bj) begin
                        m_tainted = 1'b1;
                    end
                end
                if (bus.bj) m_exp_pc = bus.br_target;
            end
        end
    end

    // Monitor: each rising inst_valid is one delivery, checked against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev_valid = 1'b0;
                mon_prev_drop  = 1'b0;
            end else begin
                if (mon_prev_valid) chk1("valid_track", bus.inst_valid, !mon_prev_drop);
                if (bus.inst_valid) begin
                    chk1("no_prefetch", bus.imem_req, 1'b0);
                    if (!mon_prev_valid) begin
                        n_deliv++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_inst got pc %h expected no delivery", bus.inst_pc);
                        end else begin
                            mon_got = exp_q.pop_front();
                            chk16("inst_pc", bus.inst_pc, mon_got[31:16]);
                            chk16("inst", bus.inst, mon_got[15:0]);
                        end
                        mon_held = {bus.inst_pc, bus.inst};
                    end else begin
                        check("inst_frozen", {bus.inst_pc, bus.inst}, mon_held);
                    end
                end
                mon_prev_valid = bus.inst_valid;
                mon_prev_drop  = bus.inst_valid && (!bus.stall || bus.bj);
            end
        end
    end

    // Instance with RESET_PC=FFFF: first fetch FFFF, then wrap to 0000.
    initial begin
        bus_w.bj        = 1'b0;
        bus_w.br_target = '0;
        bus_w.stall     = 1'b0;
        @(posedge rst);
        @(posedge clk); @(negedge clk);
        chk1("wrap_req0", bus_w.imem_req, 1'b1);
        chk16("wrap_addr0", bus_w.imem_addr, 16'hFFFF);
        @(posedge clk); @(negedge clk);
        chk1("wrap_valid0", bus_w.inst_valid, 1'b1);
        chk16("wrap_pc0", bus_w.inst_pc, 16'hFFFF);
        chk16("wrap_inst0", bus_w.inst, 16'h5A5A);
        @(posedge clk); @(negedge clk);
        chk16("wrap_addr1", bus_w.imem_addr, 16'h0000);
        @(posedge clk); @(negedge clk);
        chk16("wrap_pc1", bus_w.inst_pc, 16'h0000);
        chk16("wrap_inst1", bus_w.inst, 16'hA5A5);
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        bit found;
        bus.bj        = 1'b0;
        bus.br_target = '0;
        bus.stall     = 1'b0;
        rst           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_valid", bus.inst_valid, 1'b0);
        chk16("rst_inst", bus.inst, 16'h0000);
        chk16("rst_inst_pc", bus.inst_pc, 16'h0000);
        chk16("rst_addr", bus.imem_addr, MAIN_RST_PC);
        chk16("rst_state", {14'b0, bus.dbg_state}, {14'b0, ST_IDLE});

        // Zero-wait memory: req after edge 1, first instruction after edge 2.
        @(posedge clk);
        #1 rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); @(negedge clk);
            chk1("seq_valid", bus.inst_valid, (e % 2) == 0);
            if (e % 2 == 1) begin
                chk1("seq_req", bus.imem_req, 1'b1);
                chk16("seq_addr", bus.imem_addr, 16'((e - 1) / 2));
            end else begin
                chk16("seq_inst_pc", bus.inst_pc, 16'(e / 2 - 1));
                chk16("seq_inst", bus.inst, 16'(e / 2 - 1) ^ 16'hA5A5);
            end
        end

        // Stall holding inst_pc=5 for four cycles, then release.
        wait_req_addr("reach_pc5", 16'h0005, 40);
        @(posedge clk);
        #1 bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("stall_valid", bus.inst_valid, 1'b1);
            chk16("stall_pc", bus.inst_pc, 16'h0005);
            chk16("stall_inst", bus.inst, 16'h0005 ^ 16'hA5A5);
            chk1("stall_req", bus.imem_req, 1'b0);
            @(posedge clk);
        end
        #1;
        bus.stall = 1'b0;
        lat_cfg   = 3;
        @(posedge clk); @(negedge clk);
        chk1("unstall_req", bus.imem_req, 1'b1);
        chk16("unstall_addr", bus.imem_addr, 16'h0006);

        // Slow memory, branch in the second cycle of the request at addr 7.
        wait_req_addr("reach_pc7", 16'h0007, 20);
        @(posedge clk);
        #1;
        bus.bj        = 1'b1;
        bus.br_target = 16'h0040;
        @(posedge clk);
        #1;
        bus.bj    = 1'b0;
        bus.stall = 1'b1;
        lat_cfg   = 0;
        found     = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            chk1("squash_req", bus.imem_req, 1'b1);
            if (bus.imem_addr == 16'h0040) begin
                found = 1'b1;
            end else begin
                chk16("squash_addr", bus.imem_addr, 16'h0007);
                chk1("squash_novalid", bus.inst_valid, 1'b0);
            end
        end
        chk1("squash_redirect", found, 1'b1);

        // Branch while decode stalls the held instruction.
        wait_valid_pc("reach_pc40", 16'h0040, 20);
        @(posedge clk);
        #1;
        bus.bj        = 1'b1;
        bus.br_target = 16'h0100;
        @(posedge clk);
        #1;
        bus.bj    = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        chk1("bj_hold_valid", bus.inst_valid, 1'b0);
        chk1("bj_hold_req", bus.imem_req, 1'b1);
        chk16("bj_hold_addr", bus.imem_addr, 16'h0100);

        // Randomized branches, stalls and memory latency.
        lat_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            bus.stall = ($urandom_range(0, 3) == 0);
            if (!bus.bj && $urandom_range(0, 7) == 0) begin
                bus.bj        = 1'b1;
                bus.br_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            end else begin
                bus.bj = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.bj    = 1'b0;
        bus.stall = 1'b0;
        lat_rand  = 1'b0;

        // Reset in the middle of a pending transfer, then a stray ack in IDLE.
        lat_cfg = 5;
        repeat (15) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && wait_cnt >= 2) found = 1'b1;
        end
        chk1("reach_pending", found, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk1("rst_async_req", bus.imem_req, 1'b0);
        chk1("rst_async_valid", bus.inst_valid, 1'b0);
        chk16("rst_async_state", {14'b0, bus.dbg_state}, {14'b0, ST_IDLE});
        mem_force_ack = 1'b1;
        lat_cfg       = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 mem_force_ack = 1'b0;
        @(negedge clk);
        chk1("restart_req", bus.imem_req, 1'b1);
        chk16("restart_addr", bus.imem_addr, MAIN_RST_PC);
        chk1("restart_novalid", bus.inst_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("late_ack_valid", bus.inst_valid, 1'b1);
        chk16("late_ack_pc", bus.inst_pc, MAIN_RST_PC);
        chk16("late_ack_inst", bus.inst, MAIN_RST_PC ^ 16'hA5A5);

        // Park in HOLD so every scheduled delivery has been presented.
        @(posedge clk);
        #1 bus.stall = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk1("q_drain", exp_q.size() == 0, 1'b1);
        chk1("progress", n_deliv >= 30, 1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
